// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// ---------------------
// Write-side driver for the CPU register file. Two independent result
// producers (the ALU/execute path and the load/memory path) are merged into
// the register file's single write port through a small in-order queue. At
// most one register-file write leaves the queue per cycle.
//
// Optional feature: define REGFILE_WRITE_ARBITER_FORWARD_EN to enable the
// combinational forwarding lookup. Without it the lookup ports still exist
// but lookup_hit and lookup_data are tied to zero.
//
// Parameters:
//   WIDTH     - register data width
//   SEL_WIDTH - register select width
//   DEPTH     - queue entries (power of two, at least 2)
//
// Ports:
//   clk, rst                  - rising-edge clock, async active-high reset
//   alu_valid/ready/reg/data  - ALU result handshake
//   mem_valid/ready/reg/data  - load result handshake (has priority)
//   write/write_reg/write_data- registered register-file write port
//   busy                      - queue non-empty or a write is being presented
//   lookup_reg/hit/data       - forwarding query into pending writes

module regfile_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [SEL_WIDTH-1:0] alu_reg,
  input  logic [WIDTH-1:0]     alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [SEL_WIDTH-1:0] mem_reg,
  input  logic [WIDTH-1:0]     mem_data,
  output logic                 write,
  output logic [SEL_WIDTH-1:0] write_reg,
  output logic [WIDTH-1:0]     write_data,
  output logic                 busy,
  input  logic [SEL_WIDTH-1:0] lookup_reg,
  output logic                 lookup_hit,
  output logic [WIDTH-1:0]     lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SEL_WIDTH-1:0] entry_reg_q  [DEPTH];
  logic [SEL_WIDTH-1:0] entry_reg_d  [DEPTH];
  logic [WIDTH-1:0]     entry_data_q [DEPTH];
  logic [WIDTH-1:0]     entry_data_d [DEPTH];

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 write_q, write_d;
  logic [SEL_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [WIDTH-1:0]     write_data_q, write_data_d;

  logic [CNT_W-1:0]     free;
  logic [CNT_W-1:0]     alu_need;
  logic                 mem_live, alu_live;
  logic                 mem_take, alu_take;
  logic                 deq;
  logic [1:0]           enq_cnt;
  logic [PTR_W-1:0]     alu_slot;

  // Readiness looks only at the registered count and the current offers, so
  // a producer never sees ready depend on this cycle's dequeue. Register 0
  // offers are always accepted and simply dropped. When the load path is
  // offering a real entry it reserves a slot first, so the ALU needs two.
  always_comb begin
    mem_live  = mem_valid && (mem_reg != '0);
    alu_live  = alu_valid && (alu_reg != '0);
    free      = CNT_W'(DEPTH) - count_q;
    alu_need  = mem_live ? CNT_W'(2) : CNT_W'(1);
    mem_ready = (mem_reg == '0) || (free >= CNT_W'(1));
    alu_ready = (alu_reg == '0) || (free >= alu_need);
    mem_take  = mem_live && mem_ready;
    alu_take  = alu_live && alu_ready;
    enq_cnt   = {1'b0, mem_take} + {1'b0, alu_take};
    deq       = (count_q != '0);
  end

  // Enqueue: the load entry is older, so it takes the tail slot and a
  // same-cycle ALU entry lands right behind it.
  always_comb begin
    entry_reg_d  = entry_reg_q;
    entry_data_d = entry_data_q;
    alu_slot     = mem_take ? tail_q + PTR_W'(1) : tail_q;
    if (mem_take) begin
      entry_reg_d[tail_q]  = mem_reg;
      entry_data_d[tail_q] = mem_data;
    end
    if (alu_take) begin
      entry_reg_d[alu_slot]  = alu_reg;
      entry_data_d[alu_slot] = alu_data;
    end
    tail_d  = tail_q + PTR_W'(enq_cnt);
    count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq);
  end

  // Dequeue uses the pre-edge count, so an entry written this edge is never
  // the one presented; write_reg/write_data hold when nothing drains.
  always_comb begin
    head_d       = head_q;
    write_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (deq) begin
      head_d       = head_q + PTR_W'(1);
      write_d      = 1'b1;
      write_reg_d  = entry_reg_q[head_q];
      write_data_d = entry_data_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      write_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      write_q      <= write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Queue storage carries no reset: slots are only read once count says
  // they hold a live entry.
  always_ff @(posedge clk) begin
    entry_reg_q  <= entry_reg_d;
    entry_data_q <= entry_data_d;
  end

  assign write      = write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy       = (count_q != '0) || write_q;

`ifdef REGFILE_WRITE_ARBITER_FORWARD_EN
  logic [PTR_W-1:0] scan_idx;

  // Scanning from the output stage through the queue oldest-to-youngest and
  // letting each later match override gives the youngest pending value.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    scan_idx    = head_q;
    if (lookup_reg != '0) begin
      if (write_q && (write_reg_q == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        scan_idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (entry_reg_q[scan_idx] == lookup_reg)) begin
          lookup_hit  = 1'b1;
          lookup_data = entry_data_q[scan_idx];
        end
      end
    end
  end
`else
  logic unused_lookup;

  assign unused_lookup = ^lookup_reg;
  assign lookup_hit    = 1'b0;
  assign lookup_data   = '0;
`endif

endmodule
